// File: rtl/barrel_shift_pipe.sv
// Two-stage pipelined barrel shifter: logical/arithmetic/rotate, sticky and zero.
// Left shifts are bit-reversed so every level is a right shift.
module barrel_shift_pipe #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH),
  parameter  int SPLIT = SHW / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shift,
  input  logic             direction,
  input  logic [1:0]       mode,
  input  logic             val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op,
  output logic             sticky,
  output logic             zero
);

  function automatic logic [WIDTH-1:0] f_rev(
    input logic [WIDTH-1:0] x
  );
    for (int i = 0; i < WIDTH; i++)
      f_rev[i] = x[WIDTH-1-i];
  endfunction

  function automatic logic [WIDTH-1:0] f_lo(input int n);
    f_lo = ~({WIDTH{1'b1}} << n);
  endfunction

  function automatic logic [WIDTH-1:0] f_shr(
    input logic [WIDTH-1:0] d,
    input int               n,
    input logic             rot,
    input logic             fill
  );
    f_shr = d >> n;
    if (rot)
      f_shr = f_shr | (d << (WIDTH - n));
    else if (fill)
      f_shr = f_shr | ~({WIDTH{1'b1}} >> n);
  endfunction

  logic                 r_v1;
  logic [WIDTH-1:0]     r_d1;
  logic                 r_st1;
  logic [SHW-1:SPLIT]   r_sh1;
  logic [1:0]           r_mode1;
  logic                 r_dir1;
  logic                 r_fill1;

  logic                 w_adv2;
  logic                 w_fill;
  logic                 w_rot;
  logic [WIDTH-1:0]     w_d1;
  logic                 w_st1;
  logic                 w_rot2;
  logic [WIDTH-1:0]     w_d2;
  logic                 w_st2;
  logic [WIDTH-1:0]     w_op;

  assign w_adv2   = !out_valid || out_ready;
  assign in_ready = !r_v1 || w_adv2;

  always_comb begin
    w_fill = 1'b0;
    unique case (1'b1)
      (mode == 2'b01): w_fill = direction & A[WIDTH-1];
      (mode == 2'b10): w_fill = 1'b0;
      default:         w_fill = val;
    endcase
    w_rot = (mode == 2'b10);
    w_d1  = direction ? A : f_rev(A);
    w_st1 = 1'b0;
    for (int i = 0; i < SPLIT; i++) begin
      if (shift[i]) begin
        w_st1 = w_st1 | (~w_rot & (|(w_d1 & f_lo(1 << i))));
        w_d1  = f_shr(w_d1, 1 << i, w_rot, w_fill);
      end
    end
  end

  always_comb begin
    w_rot2 = (r_mode1 == 2'b10);
    w_d2   = r_d1;
    w_st2  = r_st1;
    for (int i = SPLIT; i < SHW; i++) begin
      if (r_sh1[i]) begin
        w_st2 = w_st2 | (~w_rot2 & (|(w_d2 & f_lo(1 << i))));
        w_d2  = f_shr(w_d2, 1 << i, w_rot2, r_fill1);
      end
    end
    w_op = r_dir1 ? w_d2 : f_rev(w_d2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_d1    <= '0;
      r_st1   <= 1'b0;
      r_sh1   <= '0;
      r_mode1 <= 2'b00;
      r_dir1  <= 1'b0;
      r_fill1 <= 1'b0;
    end else if (in_ready) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_d1    <= w_d1;
        r_st1   <= w_st1;
        r_sh1   <= shift[SHW-1:SPLIT];
        r_mode1 <= mode;
        r_dir1  <= direction;
        r_fill1 <= w_fill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      op        <= '0;
      sticky    <= 1'b0;
      zero      <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= r_v1;
      if (r_v1) begin
        op     <= w_op;
        sticky <= w_st2;
        zero   <= ~|w_op;
      end
    end
  end

endmodule
